nco_iq_downconverter: RTL and testbench

- Downstream consumer of the 8-bit NCO's sine/cosine outputs.
- Mixes a real 8-bit sample stream with the NCO quadrature pair to produce baseband I/Q.
- Accumulate-and-dump decimates by DECIM.
- Presents results through a single-entry output buffer with valid/ready handshake and a sticky overrun flag.

---
 rtl/nco_iq_downconverter_if.sv | 34 +++
 rtl/nco_iq_downconverter.sv | 175 +++++++++++++++++
 tb/tb_nco_iq_downconverter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_iq_downconverter_if.sv
// ---------------------------------------------------------------------------
// nco_iq_downconverter_if
// Bundles the sample/NCO input stream and the result handshake of the
// NCO I/Q downconverter.
//   in_valid, in_data, sine_in, cosine_in : sample and NCO pair, same cycle
//   out_valid, out_ready, i_out, q_out    : single-entry result handshake
//   overrun, ovr_clr                      : sticky overrun flag and its clear
// The master modport is the producer/consumer side that drives the inputs.
// The slave modport is the downconverter itself.
// ---------------------------------------------------------------------------
interface nco_iq_downconverter_if #(
    parameter int ACC_W = 20
);
    logic                    in_valid;
    logic signed [7:0]       in_data;
    logic signed [7:0]       sine_in;
    logic signed [7:0]       cosine_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] i_out;
    logic signed [ACC_W-1:0] q_out;
    logic                    overrun;
    logic                    ovr_clr;

    modport master (
        output in_valid, in_data, sine_in, cosine_in, out_ready, ovr_clr,
        input  out_valid, i_out, q_out, overrun
    );

    modport slave (
        input  in_valid, in_data, sine_in, cosine_in, out_ready, ovr_clr,
        output out_valid, i_out, q_out, overrun
    );
endinterface

// File: rtl/nco_iq_downconverter.sv
// ---------------------------------------------------------------------------
// nco_iq_downconverter
// Mixes a real signed 8-bit sample stream with the NCO sine/cosine pair,
// integrates DECIM accepted products (accumulate-and-dump) and hands the
// I/Q sums to a single-entry output buffer with a sticky overrun flag.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : nco_iq_downconverter_if.slave (samples in, I/Q results out)
// ---------------------------------------------------------------------------
module nco_iq_downconverter #(
    parameter int DECIM = 16,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    nco_iq_downconverter_if.slave   bus
);
    localparam int               CNT_W    = $clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    logic signed [15:0]      p_i_r;
    logic signed [15:0]      p_q_r;
    logic                    p_vld_r;
    logic signed [15:0]      prod_i_s;
    logic signed [15:0]      prod_q_s;
    logic signed [ACC_W-1:0] acc_i_r;
    logic signed [ACC_W-1:0] acc_q_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    dump_s;
    logic signed [ACC_W-1:0] sum_i_s;
    logic signed [ACC_W-1:0] sum_q_s;
    buf_state_t              state_r;
    buf_state_t              state_nxt_s;
    logic                    load_s;
    logic                    ovr_set_s;
    logic signed [ACC_W-1:0] i_out_r;
    logic signed [ACC_W-1:0] q_out_r;
    logic                    overrun_r;

    // Sign-extend a 16-bit product to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext16(input logic signed [15:0] v);
        return {{(ACC_W-16){v[15]}}, v};
    endfunction

    // Full-precision signed products; operands are widened before multiplying.
    always_comb begin
        prod_i_s = 16'(bus.in_data) * 16'(bus.cosine_in);
        prod_q_s = 16'(16'sd0 - (16'(bus.in_data) * 16'(bus.sine_in)));
    end

    // Product stage: capture on accepted samples, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p_i_r   <= 16'sd0;
            p_q_r   <= 16'sd0;
            p_vld_r <= 1'b0;
        end else begin
            p_vld_r <= bus.in_valid;
            if (bus.in_valid) begin
                p_i_r <= prod_i_s;
                p_q_r <= prod_q_s;
            end else begin
                p_i_r <= p_i_r;
                p_q_r <= p_q_r;
            end
        end
    end

    // Running sums including the current product; on the last sample of a
    // frame this is the frame result, so the dump sample is counted once.
    always_comb begin
        dump_s  = p_vld_r && (cnt_r == CNT_LAST);
        sum_i_s = acc_i_r + sext16(p_i_r);
        sum_q_s = acc_q_r + sext16(p_q_r);
    end

    // Accumulators and frame sample counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_i_r <= '0;
            acc_q_r <= '0;
            cnt_r   <= '0;
        end else if (p_vld_r) begin
            if (dump_s) begin
                acc_i_r <= '0;
                acc_q_r <= '0;
                cnt_r   <= '0;
            end else begin
                acc_i_r <= sum_i_s;
                acc_q_r <= sum_q_s;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            acc_i_r <= acc_i_r;
            acc_q_r <= acc_q_r;
            cnt_r   <= cnt_r;
        end
    end

    // Output buffer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= BUF_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output buffer next state: a dump into a full buffer is only accepted
    // when the consumer drains it on the same edge, else it is dropped.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        ovr_set_s   = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (dump_s) begin
                    state_nxt_s = BUF_FULL;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (dump_s && bus.out_ready) begin
                    load_s = 1'b1;
                end else if (dump_s) begin
                    ovr_set_s = 1'b1;
                end else if (bus.out_ready) begin
                    state_nxt_s = BUF_EMPTY;
                end else begin
                    state_nxt_s = BUF_FULL;
                end
            end
            default: begin
                state_nxt_s = BUF_EMPTY;
            end
        endcase
    end

    // Result registers and sticky overrun; a set event beats ovr_clr.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i_out_r   <= '0;
            q_out_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                i_out_r <= sum_i_s;
                q_out_r <= sum_q_s;
            end else begin
                i_out_r <= i_out_r;
                q_out_r <= q_out_r;
            end
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign bus.out_valid = (state_r == BUF_FULL);
    assign bus.i_out     = i_out_r;
    assign bus.q_out     = q_out_r;
    assign bus.overrun   = overrun_r;
endmodule

// File: tb/tb_nco_iq_downconverter.sv
module tb_nco_iq_downconverter;
    localparam int ACC_W = 20;
    localparam int D1    = 4;

    logic clk;
    logic reset;

    nco_iq_downconverter_if #(.ACC_W(ACC_W)) if1 ();
    nco_iq_downconverter_if #(.ACC_W(ACC_W)) if2 ();

    nco_iq_downconverter #(.DECIM(D1), .ACC_W(ACC_W)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    nco_iq_downconverter #(.DECIM(16), .ACC_W(ACC_W)) dut2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int i; int q; } res_t;

    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    res_t exp_q[$];

    // Frame-level reference: accepted samples are summed into a frame; a
    // completed frame reaches the one-slot buffer on the following edge.
    int m_acc_i, m_acc_q, m_cnt;
    bit m_pend;
    int m_pend_i, m_pend_q;
    bit m_full, m_ovr;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_edge(input bit v, input int d, input int s, input int c,
                              input bit rdy, input bit clr, input bit rst_n);
        bit dump_now;
        bit ovr_set;
        if (!rst_n) begin
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            m_pend = 1'b0; m_full = 1'b0; m_ovr = 1'b0;
            exp_q.delete();
            return;
        end
        dump_now = m_pend;
        m_pend   = 1'b0;
        ovr_set  = 1'b0;
        if (dump_now) begin
            if (!m_full || rdy) begin
                m_full = 1'b1;
                exp_q.push_back('{m_pend_i, m_pend_q});
            end else begin
                ovr_set = 1'b1;
            end
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (v) begin
            m_acc_i += d * c;
            m_acc_q -= d * s;
            m_cnt++;
            if (m_cnt == D1) begin
                m_pend   = 1'b1;
                m_pend_i = m_acc_i;
                m_pend_q = m_acc_q;
                m_acc_i  = 0;
                m_acc_q  = 0;
                m_cnt    = 0;
            end
        end
    endtask

    // Apply one cycle of stimulus to dut1 and advance the reference model.
    task automatic cyc(input bit v, input int d, input int s, input int c,
                       input bit rdy, input bit clr);
        if1.in_valid  = v;
        if1.in_data   = 8'(d);
        if1.sine_in   = 8'(s);
        if1.cosine_in = 8'(c);
        if1.out_ready = rdy;
        if1.ovr_clr   = clr;
        @(posedge clk);
        #2;
        model_edge(v, d, s, c, rdy, clr, reset);
    endtask

    task automatic reset_cycle();
        reset = 1'b0;
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // Monitor: status every cycle, and result data on each handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", int'(if1.out_valid), int'(m_full));
            chk("overrun", int'(if1.overrun), int'(m_ovr));
            if (reset && if1.out_valid && if1.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("sb_i_out", int'($signed(if1.i_out)), r.i);
                    chk("sb_q_out", int'($signed(if1.q_out)), r.q);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.sine_in = '0; if1.cosine_in = '0;
        if1.out_ready = 1'b0; if1.ovr_clr = 1'b0;
        if2.in_valid = 1'b0; if2.in_data = '0; if2.sine_in = '0; if2.cosine_in = '0;
        if2.out_ready = 1'b0; if2.ovr_clr = 1'b0;
        model_edge(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        reset_cycle();
        mon_en = 1'b1;
        chk("reset_valid", int'(if1.out_valid), 0);
        chk("reset_i", int'($signed(if1.i_out)), 0);

        // Test 1: basic frame, one-cycle out_valid pulse.
        for (int k = 0; k < 4; k++) cyc(1'b1, 100, 0, 127, 1'b1, 1'b0);
        chk("t1_early", int'(if1.out_valid), 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t1_valid", int'(if1.out_valid), 1);
        chk("t1_i", int'($signed(if1.i_out)), 50800);
        chk("t1_q", int'($signed(if1.q_out)), 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t1_pulse", int'(if1.out_valid), 0);

        // Test 2: in_valid gaps of 0, 1 and 3 cycles between samples.
        cyc(1'b1, -128, 127, -128, 1'b1, 1'b0);
        cyc(1'b1, -128, 127, -128, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        cyc(1'b1, -128, 127, -128, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
            chk("t2_early", int'(if1.out_valid), 0);
        end
        cyc(1'b1, -128, 127, -128, 1'b1, 1'b0);
        chk("t2_early_last", int'(if1.out_valid), 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t2_i", int'($signed(if1.i_out)), 65536);
        chk("t2_q", int'($signed(if1.q_out)), 65024);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);

        // Test 3: back-pressure through two frames gives overrun.
        for (int k = 0; k < 4; k++) cyc(1'b1, 1, 0, 1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t3_i_first", int'($signed(if1.i_out)), 4);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1, 0, 2, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("t3_ovr", int'(if1.overrun), 1);
        chk("t3_i_kept", int'($signed(if1.i_out)), 4);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t3_drained", int'(if1.out_valid), 0);
        chk("t3_ovr_sticky", int'(if1.overrun), 1);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("t3_ovr_clr", int'(if1.overrun), 0);

        // Test 4: drain and refill on the same edge.
        for (int k = 0; k < 4; k++) cyc(1'b1, 1, 0, 1, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1, 0, 3, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t4_valid", int'(if1.out_valid), 1);
        chk("t4_i", int'($signed(if1.i_out)), 12);
        chk("t4_ovr", int'(if1.overrun), 0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);

        // Test 5: reset mid-frame with a full buffer.
        for (int k = 0; k < 4; k++) cyc(1'b1, 1, 0, 5, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 10, 0, 10, 1'b0, 1'b0);
        cyc(1'b1, 10, 0, 10, 1'b0, 1'b0);
        reset_cycle();
        chk("t5_rst_valid", int'(if1.out_valid), 0);
        chk("t5_rst_i", int'($signed(if1.i_out)), 0);
        chk("t5_rst_q", int'($signed(if1.q_out)), 0);
        chk("t5_rst_ovr", int'(if1.overrun), 0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 10, 0, 10, 1'b0, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("t5_i", int'($signed(if1.i_out)), 400);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);

        // Randomized traffic checked by the scoreboard.
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(9) < 7),
                int'($urandom_range(255)) - 128,
                int'($urandom_range(255)) - 128,
                int'($urandom_range(255)) - 128,
                $urandom_range(1), ($urandom_range(19) == 0));
        end
        for (int k = 0; k < 6; k++) cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        chk("drain_queue_empty", exp_q.size(), 0);

        // Test 6: DECIM=16 full-scale frame on the second instance.
        reset_cycle();
        begin
            int e_i = 0;
            int e_q = 0;
            bit seen = 1'b0;
            if2.out_ready = 1'b1;
            for (int k = 0; k < 16; k++) begin
                if2.in_valid = 1'b1; if2.in_data = -8'sd128;
                if2.sine_in = -8'sd128; if2.cosine_in = -8'sd128;
                e_i += (-128) * (-128);
                e_q -= (-128) * (-128);
                @(posedge clk); #2;
                if (k < 15) chk("t6_early", int'(if2.out_valid), 0);
            end
            if2.in_valid = 1'b0;
            for (int k = 0; k < 6 && !seen; k++) begin
                @(posedge clk); #2;
                if (if2.out_valid) begin
                    seen = 1'b1;
                    chk("t6_i", int'($signed(if2.i_out)), e_i);
                    chk("t6_q", int'($signed(if2.q_out)), e_q);
                    chk("t6_i_const", int'($signed(if2.i_out)), 262144);
                end
            end
            chk("t6_result_seen", int'(seen), 1);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
